micro_sequencer: RTL and testbench
==================================

Name: micro_sequencer

Overview:
- Micro-program sequencer for the micro-controller datapath.
- Owns the micro-PC, addresses the combinational microcode ROM, and latches each microword into 16 control signals plus 2 choice bits.
- Chooses the next micro-address from the choice bits, the opcode dispatch table or a datapath condition.
- Supports single-step (hand clock pulse) and free-run modes, plus halt, so the board LEDs and display show one microinstruction per step.

Parameters:
- UADDR_W, 6, micro-address width (64-entry ROM).
- OP_W, 6, opcode width (64-entry dispatch table).
- FETCH_ADDR, 0, micro-address of the fetch routine and the reset value of the micro-PC.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- run_mode  in  1  1 = free run, 0 = single step.
- step  in  1  one-cycle pulse from the debounced hand clock.
- halt_req  in  1  level; forces the HALT state.
- op  in  OP_W  current instruction opcode.
- cond  in  1  branch condition from the datapath.
- uword  in  18  ROM data at uaddr; [17:2] = control, [1:0] = choice.
- cfg_we  in  1  dispatch table write strobe.
- cfg_op  in  OP_W  dispatch entry index.
- cfg_addr  in  UADDR_W  dispatch entry value.
- uaddr  out  UADDR_W  micro-PC, drives the ROM address.
- ctrl  out  16  registered control signals.
- choice  out  2  registered choice bits (for LEDs).
- ctrl_valid  out  1  one-cycle pulse per executed microword.
- state  out  2  FSM state (STEP=0, RUN=1, HALT=2).

Behaviour:
- Reset values: uaddr=FETCH_ADDR, ctrl=0, choice=0, ctrl_valid=0, state=STEP, dispatch entry i = i (identity map).
- advance = (state==RUN & run_mode & !halt_req) | (state==STEP & step & !run_mode & !halt_req).
- On an advance edge:
  - ctrl <= uword[17:2], choice <= uword[1:0], ctrl_valid <= 1.
  - uaddr <= next, selected by uword[1:0]:
    - 00: uaddr+1.
    - 01: dispatch[op].
    - 10: FETCH_ADDR.
    - 11: cond ? uaddr+2 : uaddr+1.
- Without advance: ctrl, choice and uaddr hold; ctrl_valid <= 0.
- Latency: step sampled at edge N gives ctrl/uaddr updated at edge N; ROM data for the new uaddr is valid in cycle N+1.
- Address arithmetic is modulo 2^UADDR_W: 63+1 -> 0, 63+2 -> 1, 62+2 -> 0.
- STEP -> RUN when run_mode=1; no advance that cycle, even if step=1.
- RUN -> STEP when run_mode=0; no advance that cycle.
- Any state -> HALT when halt_req=1. This has priority over advance and over the mode change, and does not advance.
- HALT -> STEP on step=1 with halt_req=0; no advance on that pulse. run_mode is ignored in HALT.
- Dispatch table:
  - cfg_we writes dispatch[cfg_op] <= cfg_addr in any state.
  - A dispatch in the same cycle as a write to the same op uses the old entry; the new entry is visible from the next cycle.
- Reset asserted mid-run: all registers return to reset values immediately (asynchronous), and the dispatch table reverts to identity.
- Step pulses wider than one cycle are a caller error; each high cycle in STEP advances once.

Decomposition:
- Package micro_seq_pkg: state encoding (STEP, RUN, HALT), choice encodings (CH_SEQ=00, CH_DISP=01, CH_FETCH=10, CH_BR=11), UADDR_W/OP_W defaults, FETCH_ADDR.
- One sub-module, dispatch_table: OP_W-indexed register file of UADDR_W entries, async reset to identity, single write port and single combinational read port (read-old on collision).
- The FSM and next-address mux stay in micro_sequencer.

Test Plan:
- Reset release, STEP mode, ROM[0]=0xABCD<<2|00, one step pulse -> ctrl=0xABCD, choice=00, uaddr=1, ctrl_valid high exactly one cycle; no further change without step.
- uaddr=5 with uword choice=01, op=0x12, entry 0x12 written to 0x30 via cfg -> after step uaddr=0x30; an unwritten op=0x07 dispatches to 0x07.
- Choice=11 at uaddr=10: cond=1 -> uaddr=12; cond=0 -> uaddr=11; at uaddr=63 with cond=1 -> uaddr=1.
- run_mode raised with step high in the same cycle -> state=RUN, no advance that cycle; then one advance per cycle for 8 cycles -> uaddr increments by 8 (choice=00); choice=10 -> uaddr=0.
- halt_req asserted during RUN -> state=HALT, ctrl/uaddr frozen; step with halt_req=0 -> STEP, uaddr unchanged; next step advances.
- reset pulled low mid-run at uaddr=0x2A after a cfg write -> uaddr=0, ctrl=0, state=STEP, dispatch entry restored to identity.

Source files
------------

// File: rtl/micro_seq_pkg.sv
// Shared encodings and default sizes for the micro-program sequencer.
// Choice bits and FSM states are plain constants so older blocks can reuse them.
package micro_seq_pkg;

    localparam int unsigned DEF_UADDR_W    = 6;
    localparam int unsigned DEF_OP_W       = 6;
    localparam int unsigned DEF_FETCH_ADDR = 0;
    localparam int unsigned CTRL_W         = 16;
    localparam int unsigned UWORD_W        = CTRL_W + 2;

    localparam logic [1:0] ST_STEP = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [1:0] CH_SEQ   = 2'b00;
    localparam logic [1:0] CH_DISP  = 2'b01;
    localparam logic [1:0] CH_FETCH = 2'b10;
    localparam logic [1:0] CH_BR    = 2'b11;

endpackage

// File: rtl/dispatch_table.sv
// Opcode-to-micro-address dispatch table; resets to the identity map.
// The read port is combinational, so a same-cycle write is seen only from the next cycle.
module dispatch_table #(
    parameter int unsigned UADDR_W = 6,
    parameter int unsigned OP_W    = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               we,
    input  logic [OP_W-1:0]    wr_op,
    input  logic [UADDR_W-1:0] wr_addr,
    input  logic [OP_W-1:0]    rd_op,
    output logic [UADDR_W-1:0] rd_addr
);

    localparam int unsigned Depth = 1 << OP_W;

    logic [UADDR_W-1:0] table_q [Depth];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Depth; i++) begin
                table_q[i] <= UADDR_W'(i);
            end
        end else if (we) begin
            table_q[wr_op] <= wr_addr;
        end
    end

    assign rd_addr = table_q[rd_op];

endmodule

// File: rtl/micro_sequencer.sv
// Micro-program sequencer: owns the micro-PC, latches each microword into control
// signals and picks the next micro-address in step, run or halt mode.
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int unsigned UADDR_W    = DEF_UADDR_W,
    parameter int unsigned OP_W       = DEF_OP_W,
    parameter int unsigned FETCH_ADDR = DEF_FETCH_ADDR
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run_mode,
    input  logic               step,
    input  logic               halt_req,
    input  logic [OP_W-1:0]    op,
    input  logic               cond,
    input  logic [UWORD_W-1:0] uword,
    input  logic               cfg_we,
    input  logic [OP_W-1:0]    cfg_op,
    input  logic [UADDR_W-1:0] cfg_addr,
    output logic [UADDR_W-1:0] uaddr,
    output logic [CTRL_W-1:0]  ctrl,
    output logic [1:0]         choice,
    output logic               ctrl_valid,
    output logic [1:0]         state
);

    localparam logic [UADDR_W-1:0] FetchAddr = UADDR_W'(FETCH_ADDR);

    logic [1:0]         state_q, state_d;
    logic [UADDR_W-1:0] uaddr_q, uaddr_d;
    logic [CTRL_W-1:0]  ctrl_q;
    logic [1:0]         choice_q;
    logic               valid_q;
    logic               advance;
    logic [UADDR_W-1:0] disp_addr;

    dispatch_table #(
        .UADDR_W (UADDR_W),
        .OP_W    (OP_W)
    ) u_dispatch (
        .clock   (clock),
        .reset   (reset),
        .we      (cfg_we),
        .wr_op   (cfg_op),
        .wr_addr (cfg_addr),
        .rd_op   (op),
        .rd_addr (disp_addr)
    );

    // halt_req outranks both advancing and mode changes; mode changes never advance.
    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        case (state_q)
            ST_STEP: begin
                if (halt_req)      state_d = ST_HALT;
                else if (run_mode) state_d = ST_RUN;
                else if (step)     advance = 1'b1;
            end
            ST_RUN: begin
                if (halt_req)       state_d = ST_HALT;
                else if (!run_mode) state_d = ST_STEP;
                else                advance = 1'b1;
            end
            ST_HALT: begin
                if (!halt_req && step) state_d = ST_STEP;
            end
            default: state_d = ST_STEP;
        endcase
    end

    // Address arithmetic wraps modulo 2^UADDR_W.
    always_comb begin
        uaddr_d = uaddr_q + UADDR_W'(1);
        unique case (uword[1:0])
            CH_SEQ:   uaddr_d = uaddr_q + UADDR_W'(1);
            CH_DISP:  uaddr_d = disp_addr;
            CH_FETCH: uaddr_d = FetchAddr;
            CH_BR:    uaddr_d = cond ? uaddr_q + UADDR_W'(2) : uaddr_q + UADDR_W'(1);
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_STEP;
            uaddr_q  <= FetchAddr;
            ctrl_q   <= '0;
            choice_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= advance;
            if (advance) begin
                uaddr_q  <= uaddr_d;
                ctrl_q   <= uword[UWORD_W-1:2];
                choice_q <= uword[1:0];
            end
        end
    end

    assign uaddr      = uaddr_q;
    assign ctrl       = ctrl_q;
    assign choice     = choice_q;
    assign ctrl_valid = valid_q;
    assign state      = state_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer; the microcode ROM is a bench-side array read at uaddr.
module tb_micro_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        run_mode, step, halt_req, cond, cfg_we;
    logic [5:0]  op, cfg_op, cfg_addr;
    logic [17:0] uword;
    logic [5:0]  uaddr;
    logic [15:0] ctrl;
    logic [1:0]  choice;
    logic        ctrl_valid;
    logic [1:0]  state;

    logic [17:0] rom [64];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clock = ~clock;

    assign uword = rom[uaddr];

    micro_sequencer u_dut (
        .clock      (clock),
        .reset      (reset),
        .run_mode   (run_mode),
        .step       (step),
        .halt_req   (halt_req),
        .op         (op),
        .cond       (cond),
        .uword      (uword),
        .cfg_we     (cfg_we),
        .cfg_op     (cfg_op),
        .cfg_addr   (cfg_addr),
        .uaddr      (uaddr),
        .ctrl       (ctrl),
        .choice     (choice),
        .ctrl_valid (ctrl_valid),
        .state      (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic step_once();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic cfg_write(input logic [5:0] o, input logic [5:0] a);
        cfg_we = 1'b1; cfg_op = o; cfg_addr = a;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        reset = 1'b0; run_mode = 1'b0; step = 1'b0; halt_req = 1'b0; cond = 1'b0;
        cfg_we = 1'b0; op = '0; cfg_op = '0; cfg_addr = '0;
        for (int i = 0; i < 64; i++) rom[i] = '0;
        rom[0] = {16'hABCD, 2'b00};
        for (int i = 1; i < 5; i++) rom[i] = {16'(16'h0100 + i), 2'b00};
        rom[5] = {16'h1111, 2'b01};

        tick(); tick();
        check("rst_uaddr", 32'(uaddr), 32'd0);
        check("rst_ctrl", 32'(ctrl), 32'd0);
        check("rst_choice", 32'(choice), 32'd0);
        check("rst_valid", 32'(ctrl_valid), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        reset = 1'b1;
        tick();

        // single step from fetch
        step_once();
        check("s1_ctrl", 32'(ctrl), 32'hABCD);
        check("s1_choice", 32'(choice), 32'd0);
        check("s1_uaddr", 32'(uaddr), 32'd1);
        check("s1_valid", 32'(ctrl_valid), 32'd1);
        tick();
        check("s1_valid_drop", 32'(ctrl_valid), 32'd0);
        check("s1_hold_uaddr", 32'(uaddr), 32'd1);
        check("s1_hold_ctrl", 32'(ctrl), 32'hABCD);

        // dispatch through a written and an unwritten entry
        repeat (4) step_once();
        check("seq_uaddr5", 32'(uaddr), 32'd5);
        cfg_write(6'h12, 6'h30);
        op = 6'h12;
        step_once();
        check("disp_written", 32'(uaddr), 32'h30);
        check("disp_ctrl", 32'(ctrl), 32'h1111);
        check("disp_choice", 32'(choice), 32'd1);
        rom[6'h30] = {16'h2222, 2'b01};
        op = 6'h07;
        step_once();
        check("disp_identity", 32'(uaddr), 32'h07);

        // write and dispatch of the same op in one cycle: old entry wins
        rom[7] = {16'h3030, 2'b01};
        cfg_we = 1'b1; cfg_op = 6'h07; cfg_addr = 6'h20; step = 1'b1;
        tick();
        cfg_we = 1'b0; step = 1'b0;
        check("disp_collide_old", 32'(uaddr), 32'h07);
        step_once();
        check("disp_new_entry", 32'(uaddr), 32'h20);

        // conditional branch, including wrap at the top of the ROM
        rom[6'h20] = {16'h4040, 2'b01};
        op = 6'h0A;
        step_once();
        check("goto_10", 32'(uaddr), 32'd10);
        rom[10] = {16'h3333, 2'b11};
        cond = 1'b1;
        step_once();
        check("br_taken", 32'(uaddr), 32'd12);
        rom[12] = {16'h4444, 2'b01};
        step_once();
        check("back_to_10", 32'(uaddr), 32'd10);
        cond = 1'b0;
        step_once();
        check("br_not_taken", 32'(uaddr), 32'd11);
        check("br_ctrl", 32'(ctrl), 32'h3333);
        check("br_choice", 32'(choice), 32'd3);
        rom[11] = {16'h5151, 2'b01};
        op = 6'h3F;
        step_once();
        check("goto_63", 32'(uaddr), 32'd63);
        rom[63] = {16'h5353, 2'b11};
        cond = 1'b1;
        step_once();
        check("br_wrap", 32'(uaddr), 32'd1);
        cond = 1'b0;

        // enter RUN with step high: no advance that cycle
        for (int i = 1; i < 9; i++) rom[i] = {16'(16'h0100 + i), 2'b00};
        rom[9] = {16'h5555, 2'b10};
        run_mode = 1'b1; step = 1'b1;
        tick();
        step = 1'b0;
        check("run_state", 32'(state), 32'd1);
        check("run_no_adv", 32'(uaddr), 32'd1);
        check("run_no_valid", 32'(ctrl_valid), 32'd0);
        repeat (8) tick();
        check("run_8_adv", 32'(uaddr), 32'd9);
        check("run_ctrl", 32'(ctrl), 32'h0108);
        check("run_valid", 32'(ctrl_valid), 32'd1);
        tick();
        check("run_fetch", 32'(uaddr), 32'd0);
        check("run_fetch_ctrl", 32'(ctrl), 32'h5555);
        check("run_fetch_choice", 32'(choice), 32'd2);

        // halt freezes everything until a step with halt_req low
        halt_req = 1'b1;
        tick();
        check("halt_state", 32'(state), 32'd2);
        check("halt_uaddr", 32'(uaddr), 32'd0);
        check("halt_valid", 32'(ctrl_valid), 32'd0);
        tick();
        check("halt_frozen_uaddr", 32'(uaddr), 32'd0);
        check("halt_frozen_ctrl", 32'(ctrl), 32'h5555);
        halt_req = 1'b0; run_mode = 1'b0;
        step_once();
        check("unhalt_state", 32'(state), 32'd0);
        check("unhalt_uaddr", 32'(uaddr), 32'd0);
        check("unhalt_valid", 32'(ctrl_valid), 32'd0);
        step_once();
        check("post_halt_adv", 32'(uaddr), 32'd1);
        check("post_halt_ctrl", 32'(ctrl), 32'hABCD);

        // asynchronous reset mid-run restores registers and identity dispatch
        cfg_write(6'h05, 6'h2A);
        rom[1] = {16'h6666, 2'b01};
        op = 6'h05;
        step_once();
        check("pre_rst_uaddr", 32'(uaddr), 32'h2A);
        rom[6'h2A] = {16'h7777, 2'b00};
        run_mode = 1'b1;
        tick();
        check("pre_rst_state", 32'(state), 32'd1);
        check("pre_rst_hold", 32'(uaddr), 32'h2A);
        reset = 1'b0;
        #1;
        check("mid_rst_uaddr", 32'(uaddr), 32'd0);
        check("mid_rst_ctrl", 32'(ctrl), 32'd0);
        check("mid_rst_state", 32'(state), 32'd0);
        tick();
        reset = 1'b1; run_mode = 1'b0;
        rom[0] = {16'h0F0F, 2'b01};
        step_once();
        check("rst_identity", 32'(uaddr), 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
